prog_loader: RTL



---
 rtl/prog_loader.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader
//   Byte-stream program/data loader for the DataPath core. Frames arrive on a
//   valid/ready byte stream and are assembled into little-endian 32-bit words
//   that are written through the core's instruction/data load ports. Also owns
//   the core's START level.
//
//   Frame: CMD, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, CNT*4 payload bytes
//          (+ trailing CSUM byte when PROG_LOADER_CSUM_EN is defined).
//   Commands: 0x50 program load, 0x44 data load, 0x47 set START,
//             0x48 clear START. Anything else sets ERR.
//
//   Build option: `define PROG_LOADER_CSUM_EN adds the trailing XOR checksum
//   byte to every frame (including 'G'/'H').
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   S_VALID, S_DATA, S_READY  input byte stream
//   TB_LOAD_PROGRAM_*         instruction-memory write strobe/addr/data
//   TB_LOAD_DATA_*            data-memory write strobe/addr/data
//   START                     core run enable (level)
//   BUSY                      frame in progress
//   DONE                      one-cycle pulse at frame completion
//   ERR                       sticky protocol error, cleared by RST only
//
// ADDR_W must lie in 9..16 (ADDR_HI supplies the bits above the low byte).
module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              S_VALID,
  input  logic [7:0]        S_DATA,
  output logic              S_READY,
  output logic              TB_LOAD_PROGRAM_CTRL,
  output logic [ADDR_W-1:0] TB_LOAD_PROGRAM_ADDR,
  output logic [31:0]       TB_LOAD_PROGRAM_DATA,
  output logic              TB_LOAD_DATA_CTRL,
  output logic [ADDR_W-1:0] TB_LOAD_DATA_ADDR,
  output logic [31:0]       TB_LOAD_DATA_DATA,
  output logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [7:0] CMD_PROG  = 8'h50;
  localparam logic [7:0] CMD_DATA  = 8'h44;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_HALT  = 8'h48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_WRITE
`ifdef PROG_LOADER_CSUM_EN
    , ST_CSUM
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              xfer;
  logic [7:0]        cmd_q;
  logic [7:0]        addr_lo_q;
  logic [7:0]        cnt_lo_q;
  logic [15:0]       cnt_in;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       remaining_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       shift_q;
  logic              done_d, err_set, start_set, start_clr;
  logic              done_q, err_q, start_q;
  logic [ADDR_W-1:0] prog_addr_q, data_addr_q;
  logic [31:0]       prog_data_q, data_data_q;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  // Ready is withheld only during the single write cycle; held low while in reset.
  assign S_READY = ~RST & (state_q != ST_WRITE);
  assign xfer    = S_VALID & S_READY;
  assign cnt_in  = {S_DATA, cnt_lo_q};

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    err_set   = 1'b0;
    start_set = 1'b0;
    start_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          case (S_DATA)
            CMD_PROG, CMD_DATA: state_d = ST_ADDR_LO;
`ifdef PROG_LOADER_CSUM_EN
            CMD_GO, CMD_HALT:   state_d = ST_CSUM;
`else
            CMD_GO: begin
              start_set = 1'b1;
              done_d    = 1'b1;
            end
            CMD_HALT: begin
              start_clr = 1'b1;
              done_d    = 1'b1;
            end
`endif
            default: err_set = 1'b1;
          endcase
        end
      end
      ST_ADDR_LO: if (xfer) state_d = ST_ADDR_HI;
      ST_ADDR_HI: if (xfer) state_d = ST_CNT_LO;
      ST_CNT_LO:  if (xfer) state_d = ST_CNT_HI;
      ST_CNT_HI: begin
        if (xfer) begin
          if (cnt_in > 16'(MAX_WORDS)) begin
            err_set = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_in == 16'd0) begin
`ifdef PROG_LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: if (xfer && byte_idx_q == 2'd3) state_d = ST_WRITE;
      ST_WRITE: begin
        if (remaining_q == 16'd1) begin
`ifdef PROG_LOADER_CSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (S_DATA != csum_q) err_set = 1'b1;
          else if (cmd_q == CMD_GO)   start_set = 1'b1;
          else if (cmd_q == CMD_HALT) start_clr = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cmd_q       <= '0;
      addr_lo_q   <= '0;
      cnt_lo_q    <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      data_addr_q <= '0;
      data_data_q <= '0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      done_q <= done_d;
      if (err_set)        err_q   <= 1'b1;
      if (start_set)      start_q <= 1'b1;
      else if (start_clr) start_q <= 1'b0;

      if (xfer) begin
        case (state_q)
          ST_IDLE:    cmd_q     <= S_DATA;
          ST_ADDR_LO: addr_lo_q <= S_DATA;
          ST_ADDR_HI: addr_q    <= {S_DATA[ADDR_W-9:0], addr_lo_q};
          ST_CNT_LO:  cnt_lo_q  <= S_DATA;
          ST_CNT_HI: begin
            remaining_q <= cnt_in;
            byte_idx_q  <= 2'd0;
          end
          ST_DATA: begin
            shift_q    <= {S_DATA, shift_q[23:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            // Output registers are loaded on the fourth byte so the strobe
            // cycle (WRITE) presents them directly; the other port holds.
            if (byte_idx_q == 2'd3) begin
              if (cmd_q == CMD_PROG) begin
                prog_addr_q <= addr_q;
                prog_data_q <= {S_DATA, shift_q};
              end else begin
                data_addr_q <= addr_q;
                data_data_q <= {S_DATA, shift_q};
              end
            end
          end
          default: ;
        endcase
      end

      if (state_q == ST_WRITE) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 16'd1;
      end

`ifdef PROG_LOADER_CSUM_EN
      if (xfer) begin
        if (state_q == ST_IDLE)      csum_q <= S_DATA;
        else if (state_q != ST_CSUM) csum_q <= csum_q ^ S_DATA;
      end
`endif
    end
  end

  assign TB_LOAD_PROGRAM_CTRL = (state_q == ST_WRITE) && (cmd_q == CMD_PROG);
  assign TB_LOAD_DATA_CTRL    = (state_q == ST_WRITE) && (cmd_q == CMD_DATA);
  assign TB_LOAD_PROGRAM_ADDR = prog_addr_q;
  assign TB_LOAD_PROGRAM_DATA = prog_data_q;
  assign TB_LOAD_DATA_ADDR    = data_addr_q;
  assign TB_LOAD_DATA_DATA    = data_data_q;
  assign START                = start_q;
  assign BUSY                 = (state_q != ST_IDLE);
  assign DONE                 = done_q;
  assign ERR                  = err_q;

endmodule
